// File: rtl/priority_decoder3_4.sv
// ---------------------------------------------------------------------------
// priority_decoder3_4
//
// Accepts a 3-bit priority code over a valid/ready handshake and decodes it
// to a registered 4-bit request line. The decode is presented until
// downstream accepts it. The block then waits a fixed hold time before it
// takes the next code. Codes 101/110/111 are illegal. They raise a sticky
// err flag and are otherwise dropped.
//
// Parameters
//   HOLD_CYCLES  post-handshake hold time in cycles (>= 1)
//   CNT_W        width of the completed-handshake counter
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   code_in     priority code to decode
//   code_valid  code_in is valid this cycle
//   code_ready  block accepts a code this cycle (IDLE only)
//   onehot      decoded request line, registered
//   out_valid   onehot holds a fresh decode awaiting acceptance
//   out_ready   downstream accepts onehot this cycle
//   busy        FSM not in IDLE
//   err         sticky illegal-code flag
//   err_clr     synchronous clear of err
//   decode_cnt  count of completed output handshakes (wraps)
// ---------------------------------------------------------------------------
module priority_decoder3_4 #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       code_in,
  input  logic             code_valid,
  output logic             code_ready,
  output logic [3:0]       onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] decode_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // The counter must be able to hold the value HOLD_CYCLES itself.
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);

  state_t          state, state_nxt;
  logic [HC_W-1:0] hold_cnt, hold_cnt_nxt;
  logic            legal;
  logic [3:0]      decoded;
  logic            accept;
  logic            handshake;

  // ---------------------------------------------------------------------
  // Code decode
  // ---------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first. A
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    legal   = 1'b1;
    decoded = 4'b0000;
    case (code_in)
      3'b100:  decoded = 4'b1000;
      3'b011:  decoded = 4'b0100;
      3'b010:  decoded = 4'b0010;
      3'b001:  decoded = 4'b0001;
      3'b000:  decoded = 4'b0000;
      default: legal   = 1'b0;
    endcase
  end

  // Handshake qualifiers are decoded straight from state so that they are
  // glitch-free with respect to the data inputs.
  assign code_ready = (state == IDLE);
  assign out_valid  = (state == PRESENT);
  assign busy       = (state != IDLE);
  assign accept     = code_valid && code_ready;
  assign handshake  = out_valid && out_ready;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE: begin
        // An illegal code is accepted but dropped. The FSM stays in IDLE.
        if (accept && legal) state_nxt = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = HC_W'(HOLD_CYCLES);
        end
      end
      HOLD: begin
        // Leaving on the 1 -> 0 step makes HOLD last exactly HOLD_CYCLES.
        hold_cnt_nxt = hold_cnt - HC_W'(1);
        if (hold_cnt == HC_W'(1)) state_nxt = IDLE;
      end
      default: begin
        state_nxt    = IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All
  // registers then update together, and the order of the statements does
  // not matter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // onehot changes only on a legal accept. It stays driven through
  // PRESENT, HOLD and the following IDLE period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      onehot <= 4'b0000;
    end else if (accept && legal) begin
      onehot <= decoded;
    end
  end

  // When an illegal accept coincides with err_clr, the set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (accept && !legal) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  // Natural binary wrap at 2^CNT_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      decode_cnt <= '0;
    end else if (handshake) begin
      decode_cnt <= decode_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_priority_decoder3_4.sv
module tb_priority_decoder3_4;

  localparam int HOLD  = 4;
  localparam int CW    = 2;
  localparam int NRAND = 400;

  logic          clk;
  logic          reset_n;
  logic [2:0]    code_in;
  logic          code_valid;
  logic          code_ready;
  logic [3:0]    onehot;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          err;
  logic          err_clr;
  logic [CW-1:0] decode_cnt;

  int checks;
  int errors;

  // Behavioural model: transaction-level view of the block.
  logic [3:0] m_onehot;
  bit         m_err;
  bit         m_present;  // a decode is waiting for downstream
  int         m_hold;     // cycles of hold time still to elapse
  int         m_cnt;

  priority_decoder3_4 #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .onehot     (onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err        (err),
    .err_clr    (err_clr),
    .decode_cnt (decode_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Code n (1..4) selects bit n-1; code 0 selects nothing; 5..7 are illegal.
  function automatic logic [3:0] ref_decode(input int code);
    if (code == 0) return 4'b0000;
    return 4'(1 << (code - 1));
  endfunction

  function automatic bit m_ready();
    return !m_present && (m_hold == 0);
  endfunction

  function automatic void model_reset();
    m_onehot  = 4'b0000;
    m_err     = 1'b0;
    m_present = 1'b0;
    m_hold    = 0;
    m_cnt     = 0;
  endfunction

  // Advances the model by one rising edge, using the inputs seen at that edge.
  function automatic void model_edge();
    bit acc;
    int code;
    acc  = code_valid && m_ready();
    code = int'(code_in);
    if (m_present) begin
      if (out_ready) begin
        m_cnt     = (m_cnt + 1) % (1 << CW);
        m_present = 1'b0;
        m_hold    = HOLD;
      end
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
    end
    if (acc && code <= 4) begin
      m_onehot  = ref_decode(code);
      m_present = 1'b1;
    end
    if (acc && code > 4) m_err = 1'b1;
    else if (err_clr)    m_err = 1'b0;
  endfunction

  // One clock: edge, model update, then settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    code_valid = 1'b0;
    err_clr    = 1'b0;
    out_ready  = 1'b0;
    code_in    = 3'b000;
    reset_n    = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  // Drains any operation in progress, with a bounded wait.
  task automatic wait_idle();
    int n;
    code_valid = 1'b0;
    out_ready  = 1'b1;
    n = 0;
    while (!code_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!code_ready) begin
      errors++;
      $display("FAIL wait_idle: code_ready=%0b after %0d cycles, required 1", code_ready, n);
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    code_valid = 1'b0;
    code_in    = 3'b000;
    out_ready  = 1'b0;
    err_clr    = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({code_ready, onehot, out_valid, busy, err, decode_cnt} !== {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b oh=%b ov=%0b busy=%0b err=%0b cnt=%0d, required 1 0000 0 0 0 0",
               code_ready, onehot, out_valid, busy, err, decode_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_legal_decode();
    int cnt0;
    cnt0 = m_cnt;
    code_in = 3'b011; code_valid = 1'b1; out_ready = 1'b1;
    step();
    code_valid = 1'b0;
    checks++;
    if (onehot !== 4'b0100 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL legal_present: oh=%b ov=%0b, required 0100 1", onehot, out_valid);
    end
    for (int i = 0; i < HOLD; i++) begin
      step();
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || code_ready !== 1'b0 || onehot !== 4'b0100) begin
        errors++;
        $display("FAIL legal_hold%0d: busy=%0b ov=%0b rdy=%0b oh=%b, required 1 0 0 0100",
                 i, busy, out_valid, code_ready, onehot);
      end
    end
    step();
    checks++;
    if (code_ready !== 1'b1 || busy !== 1'b0 || decode_cnt !== CW'(cnt0 + 1)) begin
      errors++;
      $display("FAIL legal_done: rdy=%0b busy=%0b cnt=%0d, required 1 0 %0d",
               code_ready, busy, decode_cnt, (cnt0 + 1) % (1 << CW));
    end
  endtask

  task automatic test_backpressure();
    int cnt0;
    wait_idle();
    cnt0 = m_cnt;
    code_in = 3'b100; code_valid = 1'b1; out_ready = 1'b0;
    step();
    code_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (onehot !== 4'b1000 || out_valid !== 1'b1 || code_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure%0d: oh=%b ov=%0b rdy=%0b, required 1000 1 0",
                 i, onehot, out_valid, code_ready);
      end
      // A code offered while stalled must be ignored.
      code_in = 3'b001; code_valid = (i % 2 == 0);
      step();
      code_valid = 1'b0;
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || decode_cnt !== CW'(cnt0 + 1) || onehot !== 4'b1000) begin
      errors++;
      $display("FAIL backpressure_release: busy=%0b ov=%0b cnt=%0d oh=%b, required 1 0 %0d 1000",
               busy, out_valid, decode_cnt, onehot, (cnt0 + 1) % (1 << CW));
    end
  endtask

  task automatic test_illegal();
    logic [3:0] oh0;
    wait_idle();
    oh0 = m_onehot;
    code_in = 3'b110; code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || onehot !== oh0 || out_valid !== 1'b0 || code_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_set: err=%0b oh=%b ov=%0b rdy=%0b, required 1 %b 0 1",
               err, onehot, out_valid, code_ready, oh0);
    end
    code_in = 3'b111; code_valid = 1'b1; err_clr = 1'b1;
    step();
    code_valid = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_set_wins: err=%0b, required 1", err);
    end
    step();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0 || onehot !== oh0) begin
      errors++;
      $display("FAIL illegal_clear: err=%0b oh=%b, required 0 %b", err, onehot, oh0);
    end
  endtask

  task automatic test_zero_wrap();
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      wait_idle();
      code_in = 3'b000; code_valid = 1'b1;
      step();
      code_valid = 1'b0;
      checks++;
      if (onehot !== 4'b0000 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL zero_present%0d: oh=%b ov=%0b, required 0000 1", k, onehot, out_valid);
      end
      step();
      checks++;
      if (decode_cnt !== CW'(k % 4)) begin
        errors++;
        $display("FAIL zero_cnt%0d: cnt=%0d, required %0d", k, decode_cnt, k % 4);
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_idle();
    code_in = 3'b001; code_valid = 1'b1; out_ready = 1'b1;
    step();                 // accepted, PRESENT
    code_valid = 1'b0;
    step();                 // handshake, HOLD cycle 1
    step();                 // HOLD cycle 2
    checks++;
    if (busy !== 1'b1 || onehot !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_pre: busy=%0b oh=%b, required 1 0001", busy, onehot);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({code_ready, onehot, out_valid, busy, err, decode_cnt} !== {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_async: rdy=%0b oh=%b ov=%0b busy=%0b err=%0b cnt=%0d, required 1 0000 0 0 0 0",
               code_ready, onehot, out_valid, busy, err, decode_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (code_ready !== 1'b1 || decode_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_release: rdy=%0b cnt=%0d, required 1 0", code_ready, decode_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    wait_idle();
    first  = -1;
    second = -1;
    code_in = 3'b001; code_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20 && second < 0; k++) begin
      bit will_accept;
      will_accept = code_ready && code_valid;
      step();
      if (will_accept) begin
        if (first < 0) begin
          first = k;
          checks++;
          if (onehot !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_first: oh=%b, required 0001", onehot);
          end
          code_in = 3'b010;
        end else begin
          second = k;
          checks++;
          if (onehot !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_second: oh=%b, required 0010", onehot);
          end
        end
      end
    end
    code_valid = 1'b0;
    checks++;
    if (first < 0 || second < 0 || (second - first) !== HOLD + 2) begin
      errors++;
      $display("FAIL b2b_spacing: first=%0d second=%0d, required spacing %0d", first, second, HOLD + 2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < NRAND; i++) begin
      code_in    = 3'($urandom_range(0, 7));
      code_valid = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      err_clr    = ($urandom_range(0, 7) == 0);
      step();
      checks++;
      if (code_ready !== m_ready() || out_valid !== m_present || busy !== !m_ready() ||
          onehot !== m_onehot || err !== m_err || decode_cnt !== CW'(m_cnt)) begin
        errors++;
        $display("FAIL random%0d: rdy=%0b ov=%0b busy=%0b oh=%b err=%0b cnt=%0d, required %0b %0b %0b %b %0b %0d",
                 i, code_ready, out_valid, busy, onehot, err, decode_cnt,
                 m_ready(), m_present, !m_ready(), m_onehot, m_err, m_cnt);
      end
    end
    code_valid = 1'b0;
    err_clr    = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_legal_decode();
    test_backpressure();
    test_illegal();
    test_zero_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_decoder3_4.md
PRIORITY_DECODER3_4 -- requirements
Module: priority_decoder3_4

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, sets the post-handshake hold time in clock cycles (legal range >= 1).
REQ-002 Parameter CNT_W, default 8, sets the decode counter width.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 code_in  input  3  priority code to decode.
REQ-006 code_valid  input  1  code_in is valid this cycle.
REQ-007 code_ready  output  1  block accepts a code this cycle.
REQ-008 onehot  output  4  decoded request line, registered.
REQ-009 out_valid  output  1  onehot holds a fresh decode awaiting acceptance.
REQ-010 out_ready  input  1  downstream accepts onehot this cycle.
REQ-011 busy  output  1  FSM not in IDLE.
REQ-012 err  output  1  sticky illegal-code flag.
REQ-013 err_clr  input  1  synchronous clear of err.
REQ-014 decode_cnt  output  CNT_W  count of completed output handshakes.

Function
REQ-015 Input handshake: a code is accepted on a rising edge where code_valid=1 and code_ready=1.
REQ-016 code_ready shall be 1 only in state IDLE, decoded combinationally from state.
REQ-017 Decode map: 100->1000, 011->0100, 010->0010, 001->0001, 000->0000.
REQ-018 Codes 101, 110 and 111 are illegal.
REQ-019 FSM states: IDLE, PRESENT, HOLD.
REQ-020 IDLE with legal accept: load onehot and go to PRESENT. out_valid=1 in the cycle after accept (latency 1).
REQ-021 IDLE with illegal accept: set err the next cycle, stay in IDLE, leave onehot unchanged, raise no out_valid.
REQ-022 PRESENT: out_valid=1; when out_ready=1, complete the handshake, go to HOLD, and load the hold counter with HOLD_CYCLES.
REQ-023 PRESENT with out_ready=0: stay in PRESENT, keep onehot and out_valid stable, and accept no input.
REQ-024 HOLD: out_valid=0 and onehot stays driven. Decrement the hold counter each cycle; return to IDLE in the cycle the counter goes from 1 to 0, so HOLD lasts exactly HOLD_CYCLES cycles.
REQ-025 onehot shall change only on a legal accept and shall otherwise hold its last value in all states.
REQ-026 Code 000 is legal: it produces onehot=0000 with out_valid=1 and a normal handshake.
REQ-027 decode_cnt increments by 1 on each out_valid&&out_ready cycle and wraps from 2^CNT_W-1 to 0.
REQ-028 err_clr=1 clears err next cycle. If it coincides with an illegal accept, err stays set (set wins).
REQ-029 busy = (state != IDLE).
REQ-030 Steady-state throughput with out_ready held high: one code per HOLD_CYCLES+2 cycles.
REQ-031 code_valid while code_ready=0 is ignored; the source must hold the code until accepted.

Reset
REQ-032 reset_n=0 shall immediately force: state=IDLE, onehot=0000, out_valid=0, err=0, decode_cnt=0, hold counter=0.
REQ-033 Reset asserted mid-PRESENT or mid-HOLD shall abort the operation with no handshake counted; code_ready=1 in the first cycle after release.
REQ-034 Deassertion takes effect at the first rising edge of clk after reset_n=1.

Verification
REQ-035 Legal decode: IDLE, code_in=011, code_valid=1, out_ready=1 -> next cycle onehot=0100, out_valid=1; then 4 cycles with busy=1, out_valid=0; code_ready=1 again 6 cycles after accept; decode_cnt=1.
REQ-036 Backpressure: code_in=100 accepted, out_ready=0 for 10 cycles -> onehot=1000, out_valid=1 stable and code_ready=0 throughout; out_ready=1 -> HOLD entered, decode_cnt+1.
REQ-037 Illegal code: code_in=110 accepted -> err=1 next cycle, onehot unchanged, out_valid=0, state IDLE. Then err_clr=1 together with code_in=111 accepted -> err stays 1. Then err_clr alone -> err=0.
REQ-038 Zero code and wrap: with CNT_W=2, 4 handshakes of code 000 -> onehot=0000 each time, decode_cnt sequence 1,2,3,0.
REQ-039 Reset mid-operation: assert reset_n=0 during HOLD cycle 2 -> outputs at reset values without waiting for clk; code_ready=1 after release.
REQ-040 Back-to-back: code_valid held high with codes 001, 010 and out_ready=1 -> second accept occurs exactly HOLD_CYCLES+2 cycles after the first; onehot 0001 then 0010.
